// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter: round-robin sharing of one binary-to-BCD converter
// among C_CH channels, with per-channel result registers and a watchdog.
module bcd_conv_arbiter #(
    parameter int C_CH      = 4,
    parameter int C_DAT_W   = 27,
    parameter int C_TIMEOUT = 63
) (
    input  logic                    CK_i,
    input  logic                    ARST_i,
    input  logic                    EN_CK_i,
    input  logic [C_CH-1:0]         REQ_i,
    input  logic [C_CH*C_DAT_W-1:0] DAT_i,
    output logic [C_CH-1:0]         PEND_o,
    output logic [C_CH-1:0]         GNT_o,
    output logic [C_CH*32-1:0]      QQ_o,
    output logic [C_CH-1:0]         DONE_o,
    output logic [C_CH-1:0]         ERR_o,
    output logic                    CONV_REQ_o,
    output logic [C_DAT_W-1:0]      CONV_DAT_o,
    input  logic [31:0]             CONV_QQ_i,
    input  logic                    CONV_DONE_i
);

    localparam int TMR_W = $clog2(C_TIMEOUT + 1);
    localparam int PTR_W = $clog2(C_CH);
    localparam logic [C_CH-1:0] ONE_CH = C_CH'(1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(C_TIMEOUT);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(C_CH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t               state_q;
    logic [C_CH-1:0]      pend_q;
    logic [C_DAT_W-1:0]   hold_q [C_CH];
    logic [C_CH-1:0]      gnt_q;
    logic [PTR_W-1:0]     sel_q;
    logic [PTR_W-1:0]     ptr_q;
    logic [TMR_W-1:0]     tmr_q;
    logic [C_DAT_W-1:0]   dat_q;
    logic [31:0]          qq_q [C_CH];
    logic [C_CH-1:0]      done_q;
    logic [C_CH-1:0]      err_q;

    logic                 found;
    logic [PTR_W-1:0]     pick;
    logic [PTR_W-1:0]     cand;
    logic [PTR_W-1:0]     ptr_nxt;
    logic                 in_issue;
    logic                 fin_ok;
    logic                 fin_to;
    logic                 fin;

    // First pending channel, scanning upward from the round-robin pointer
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 0; i < C_CH; i++) begin
            cand = PTR_W'((int'(ptr_q) + i) % C_CH);
            if (!found && pend_q[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Completion decode; a DONE on the timeout edge takes priority
    always_comb begin
        in_issue = (state_q == S_ISSUE);
        fin_ok   = (state_q == S_WAIT) && CONV_DONE_i;
        fin_to   = (state_q == S_WAIT) && !CONV_DONE_i && (tmr_q == TMR_MAX);
        fin      = fin_ok || fin_to;
        ptr_nxt  = (sel_q == PTR_LAST) ? '0 : sel_q + PTR_W'(1);
    end

    // Request capture; a repeat request simply refreshes the held value
    always_ff @(posedge CK_i or posedge ARST_i) begin
        if (ARST_i) begin
            pend_q <= '0;
            for (int k = 0; k < C_CH; k++) begin
                hold_q[k] <= '0;
            end
        end else if (EN_CK_i) begin
            for (int k = 0; k < C_CH; k++) begin
                if (REQ_i[k]) begin
                    pend_q[k] <= 1'b1;
                    hold_q[k] <= DAT_i[k*C_DAT_W +: C_DAT_W];
                end
            end
            if (in_issue && !REQ_i[sel_q]) begin
                pend_q[sel_q] <= 1'b0;
            end
        end
    end

    // Scheduler FSM: pick, issue one start pulse, wait for DONE or timeout
    always_ff @(posedge CK_i or posedge ARST_i) begin
        if (ARST_i) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            tmr_q   <= '0;
            dat_q   <= '0;
        end else if (EN_CK_i) begin
            unique case (state_q)
                S_IDLE: begin
                    if (found) begin
                        sel_q   <= pick;
                        gnt_q   <= ONE_CH << pick;
                        dat_q   <= hold_q[pick];
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    tmr_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (fin) begin
                        gnt_q   <= '0;
                        ptr_q   <= ptr_nxt;
                        state_q <= S_IDLE;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Per-channel result, error flag and one-cycle completion pulse
    always_ff @(posedge CK_i or posedge ARST_i) begin
        if (ARST_i) begin
            done_q <= '0;
            err_q  <= '0;
            for (int k = 0; k < C_CH; k++) begin
                qq_q[k] <= '0;
            end
        end else if (EN_CK_i) begin
            done_q <= '0;
            if (fin) begin
                done_q[sel_q] <= 1'b1;
            end
            if (fin_ok) begin
                qq_q[sel_q]  <= CONV_QQ_i;
                err_q[sel_q] <= 1'b0;
            end else if (fin_to) begin
                err_q[sel_q] <= 1'b1;
            end
        end
    end

    // Flatten the result registers onto the output bus
    always_comb begin
        QQ_o = '0;
        for (int k = 0; k < C_CH; k++) begin
            QQ_o[k*32 +: 32] = qq_q[k];
        end
    end

    assign PEND_o     = pend_q;
    assign GNT_o      = gnt_q;
    assign DONE_o     = done_q;
    assign ERR_o      = err_q;
    assign CONV_REQ_o = in_issue;
    assign CONV_DAT_o = dat_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// tb_bcd_conv_arbiter: directed and randomized checks of the converter
// arbiter against a round-robin/BCD reference model and a converter model.
module tb_bcd_conv_arbiter;

    localparam int C_CH = 4;
    localparam int W    = 27;
    localparam int TO   = 63;
    localparam int LAT  = 29;

    logic              CK_i;
    logic              ARST_i;
    logic              EN_CK_i;
    logic [C_CH-1:0]   REQ_i;
    logic [C_CH*W-1:0] DAT_i;
    logic [C_CH-1:0]   PEND_o;
    logic [C_CH-1:0]   GNT_o;
    logic [C_CH*32-1:0] QQ_o;
    logic [C_CH-1:0]   DONE_o;
    logic [C_CH-1:0]   ERR_o;
    logic              CONV_REQ_o;
    logic [W-1:0]      CONV_DAT_o;
    logic [31:0]       CONV_QQ_i;
    logic              CONV_DONE_i;

    bcd_conv_arbiter #(
        .C_CH(C_CH), .C_DAT_W(W), .C_TIMEOUT(TO)
    ) dut (
        .CK_i(CK_i), .ARST_i(ARST_i), .EN_CK_i(EN_CK_i),
        .REQ_i(REQ_i), .DAT_i(DAT_i),
        .PEND_o(PEND_o), .GNT_o(GNT_o), .QQ_o(QQ_o),
        .DONE_o(DONE_o), .ERR_o(ERR_o),
        .CONV_REQ_o(CONV_REQ_o), .CONV_DAT_o(CONV_DAT_o),
        .CONV_QQ_i(CONV_QQ_i), .CONV_DONE_i(CONV_DONE_i)
    );

    int total = 0;
    int bad   = 0;

    bit         conv_mute = 0;
    int         conv_cnt  = 0;
    int         conv_dones = 0;
    logic [W-1:0] conv_val = '0;

    int         gnt_q[$];
    int         exp_ord[$];
    int         done_cnt[C_CH];
    int         req_pulses = 0;
    logic [C_CH-1:0] prev_gnt = '0;
    logic       prev_req = 1'b0;
    int         mptr = 0;

    initial begin
        CK_i = 1'b0;
        forever #5 CK_i = ~CK_i;
    end

    function automatic logic [31:0] to_bcd(input int unsigned v);
        logic [31:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int d = 0; d < 8; d++) begin
            r[d*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] qq(input int k);
        return QQ_o[k*32 +: 32];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge CK_i);
    endtask

    // Round-robin reference: serve pending set in order from mptr
    task automatic model_order(input logic [C_CH-1:0] m);
        logic [C_CH-1:0] p;
        p = m;
        while (p != 0) begin
            for (int i = 0; i < C_CH; i++) begin
                int c;
                c = (mptr + i) % C_CH;
                if (p[c]) begin
                    exp_ord.push_back(c);
                    p[c] = 1'b0;
                    mptr = (c + 1) % C_CH;
                    break;
                end
            end
        end
    endtask

    task automatic post(input int k, input int unsigned v);
        DAT_i[k*W +: W] = W'(v);
        REQ_i = 4'b0001 << k;
        tick();
        REQ_i = '0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((PEND_o != 0 || GNT_o != 0) && n < budget) begin
            tick();
            n++;
        end
        chk("idle_budget", 64'(n < budget), 64'd1);
        tick();
    endtask

    task automatic wait_req(input int budget);
        int n;
        n = 0;
        while (!CONV_REQ_o && n < budget) begin
            tick();
            n++;
        end
        chk("req_budget", 64'(CONV_REQ_o), 64'd1);
    endtask

    task automatic chk_order(input string tag);
        chk({tag, "_len"}, 64'(gnt_q.size()), 64'(exp_ord.size()));
        for (int i = 0; i < exp_ord.size() && i < gnt_q.size(); i++) begin
            chk({tag, "_gnt"}, 64'(gnt_q[i]), 64'(exp_ord[i]));
        end
        gnt_q.delete();
        exp_ord.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pend"}, 64'(PEND_o), 64'd0);
        chk({tag, "_gnt"}, 64'(GNT_o), 64'd0);
        chk({tag, "_done"}, 64'(DONE_o), 64'd0);
        chk({tag, "_err"}, 64'(ERR_o), 64'd0);
        chk({tag, "_creq"}, 64'(CONV_REQ_o), 64'd0);
        chk({tag, "_cdat"}, 64'(CONV_DAT_o), 64'd0);
        chk({tag, "_qq_lo"}, QQ_o[63:0], 64'd0);
        chk({tag, "_qq_hi"}, QQ_o[127:64], 64'd0);
    endtask

    // Observer: grant order, completion pulses, converter start pulses
    initial begin
        forever begin
            @(negedge CK_i);
            if (GNT_o != 0 && prev_gnt == 0) begin
                for (int k = 0; k < C_CH; k++) begin
                    if (GNT_o[k]) gnt_q.push_back(k);
                end
            end
            for (int k = 0; k < C_CH; k++) begin
                if (DONE_o[k]) done_cnt[k]++;
            end
            if (CONV_REQ_o && !prev_req) req_pulses++;
            prev_gnt = GNT_o;
            prev_req = CONV_REQ_o;
        end
    end

    // Converter model: exact BCD, fixed latency in enabled cycles
    initial begin
        CONV_DONE_i = 1'b0;
        CONV_QQ_i   = '0;
        forever begin
            @(negedge CK_i);
            #1;
            if (EN_CK_i) begin
                CONV_DONE_i = 1'b0;
                if (CONV_REQ_o) begin
                    if (!conv_mute) begin
                        conv_cnt = LAT;
                        conv_val = CONV_DAT_o;
                    end
                end else if (conv_cnt > 0) begin
                    conv_cnt--;
                    if (conv_cnt == 0) begin
                        CONV_DONE_i = 1'b1;
                        CONV_QQ_i   = to_bcd(int'(conv_val));
                        conv_dones++;
                    end
                end
            end
        end
    end

    initial begin
        int n;
        int base_done;
        int base_req;
        int base_conv;
        logic [31:0] exp_qq [C_CH];
        logic [C_CH-1:0] m;
        int unsigned v;

        ARST_i  = 1'b1;
        EN_CK_i = 1'b1;
        REQ_i   = '0;
        DAT_i   = '0;
        for (int k = 0; k < C_CH; k++) exp_qq[k] = '0;
        #1;
        chk_all_zero("rst");
        tick(3);
        ARST_i = 1'b0;
        tick(2);

        // single request on channel 1
        post(1, 12345678);
        chk("t1_pend", 64'(PEND_o), 64'b0010);
        chk("t1_gnt0", 64'(GNT_o), 64'd0);
        tick();
        chk("t1_gnt", 64'(GNT_o), 64'b0010);
        chk("t1_creq", 64'(CONV_REQ_o), 64'd1);
        chk("t1_cdat", 64'(CONV_DAT_o), 64'd12345678);
        tick();
        chk("t1_creq_low", 64'(CONV_REQ_o), 64'd0);
        chk("t1_pend_clr", 64'(PEND_o), 64'd0);
        n = 0;
        while (DONE_o == 0 && n < 100) begin
            tick();
            n++;
        end
        chk("t1_done", 64'(DONE_o), 64'b0010);
        chk("t1_qq", 64'(qq(1)), 64'h12345678);
        chk("t1_err", 64'(ERR_o), 64'd0);
        tick();
        chk("t1_done_pulse", 64'(DONE_o), 64'd0);
        chk("t1_gnt_rel", 64'(GNT_o), 64'd0);
        chk("t1_req_pulses", 64'(req_pulses), 64'd1);

        // all four at once from a fresh pointer, then a sparse pair
        ARST_i = 1'b1;
        tick();
        ARST_i = 1'b0;
        tick();
        mptr = 0;
        gnt_q.delete();
        DAT_i[0*W +: W] = W'(1);
        DAT_i[1*W +: W] = W'(22);
        DAT_i[2*W +: W] = W'(333);
        DAT_i[3*W +: W] = W'(4444);
        REQ_i = 4'b1111;
        tick();
        REQ_i = '0;
        model_order(4'b1111);
        wait_idle(400);
        chk_order("t2a");
        chk("t2_qq0", 64'(qq(0)), 64'h1);
        chk("t2_qq1", 64'(qq(1)), 64'h22);
        chk("t2_qq2", 64'(qq(2)), 64'h333);
        chk("t2_qq3", 64'(qq(3)), 64'h4444);
        exp_qq[0] = 32'h1;
        exp_qq[1] = 32'h22;
        exp_qq[2] = 32'h333;
        exp_qq[3] = 32'h4444;
        DAT_i[0*W +: W] = W'(2024);
        DAT_i[2*W +: W] = W'(7);
        REQ_i = 4'b0101;
        tick();
        REQ_i = '0;
        model_order(4'b0101);
        wait_idle(200);
        chk_order("t2b");
        chk("t2b_qq0", 64'(qq(0)), 64'h2024);
        chk("t2b_qq2", 64'(qq(2)), 64'h7);

        // overwrite of a pending request while the converter is busy
        base_done = done_cnt[2];
        base_req  = req_pulses;
        post(0, 1000);
        tick();
        post(2, 5);
        tick(3);
        post(2, 99999999);
        model_order(4'b0001);
        model_order(4'b0100);
        wait_idle(200);
        chk_order("t3");
        chk("t3_qq2", 64'(qq(2)), 64'h99999999);
        chk("t3_done_cnt", 64'(done_cnt[2] - base_done), 64'd1);
        chk("t3_req_cnt", 64'(req_pulses - base_req), 64'd2);

        // converter never answers channel 3
        conv_mute = 1'b1;
        post(3, 777);
        wait_req(10);
        tick();
        n = 0;
        while (!DONE_o[3] && n < 200) begin
            tick();
            n++;
        end
        chk("t4_to_cycles", 64'(n), 64'(TO + 1));
        chk("t4_err", 64'(ERR_o), 64'b1000);
        chk("t4_done", 64'(DONE_o), 64'b1000);
        chk("t4_qq3_kept", 64'(qq(3)), 64'h4444);
        tick();
        chk("t4_done_pulse", 64'(DONE_o), 64'd0);
        chk("t4_gnt_rel", 64'(GNT_o), 64'd0);
        conv_mute = 1'b0;
        model_order(4'b1000);
        post(3, 31415926);
        model_order(4'b1000);
        wait_idle(200);
        chk("t4_err_clr", 64'(ERR_o), 64'd0);
        chk("t4_qq3", 64'(qq(3)), 64'h31415926);

        // reset in the middle of a wait, then a late converter DONE
        post(0, 4242);
        wait_req(10);
        tick(11);
        #2;
        ARST_i = 1'b1;
        #1;
        chk_all_zero("t5");
        tick(2);
        ARST_i = 1'b0;
        base_done = done_cnt[0] + done_cnt[1] + done_cnt[2] + done_cnt[3];
        base_conv = conv_dones;
        tick(40);
        chk("t5_late_seen", 64'(conv_dones - base_conv), 64'd1);
        chk("t5_no_done", 64'(done_cnt[0] + done_cnt[1] + done_cnt[2]
                              + done_cnt[3] - base_done), 64'd0);
        chk("t5_qq_lo", QQ_o[63:0], 64'd0);
        chk("t5_qq_hi", QQ_o[127:64], 64'd0);
        chk("t5_gnt", 64'(GNT_o), 64'd0);
        for (int k = 0; k < C_CH; k++) exp_qq[k] = '0;
        mptr = 0;
        gnt_q.delete();
        exp_ord.delete();

        // clock-enable freeze while the start pulse is up
        base_done = done_cnt[1];
        base_req  = req_pulses;
        post(1, 8765432);
        wait_req(10);
        EN_CK_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t6_frz_req", 64'(CONV_REQ_o), 64'd1);
        end
        EN_CK_i = 1'b1;
        model_order(4'b0010);
        wait_idle(200);
        chk_order("t6");
        chk("t6_qq1", 64'(qq(1)), 64'h08765432);
        chk("t6_done_cnt", 64'(done_cnt[1] - base_done), 64'd1);
        chk("t6_req_cnt", 64'(req_pulses - base_req), 64'd1);
        chk("t6_err", 64'(ERR_o), 64'd0);
        exp_qq[1] = 32'h08765432;

        // randomized request sets against the reference model
        for (int r = 0; r < 8; r++) begin
            m = 4'($urandom_range(1, 15));
            for (int k = 0; k < C_CH; k++) begin
                if (m[k]) begin
                    v = $urandom_range(0, 99999999);
                    DAT_i[k*W +: W] = W'(v);
                    exp_qq[k] = to_bcd(v);
                end
            end
            REQ_i = m;
            tick();
            REQ_i = '0;
            model_order(m);
            wait_idle(600);
            chk_order("rnd");
            for (int k = 0; k < C_CH; k++) begin
                chk("rnd_qq", 64'(qq(k)), 64'(exp_qq[k]));
            end
            chk("rnd_err", 64'(ERR_o), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
